// File: rtl/stall_unit.sv
// Pipeline hazard and memory-wait control: freezes the pipeline on data-memory
// waits, flushes on taken branches, inserts a bubble on load-use hazards.
module stall_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             mem_read_ID_EXE,
  input  logic [4:0]       regfile_waddr_ID_EXE,
  input  logic [4:0]       instruction_IF_ID_Rs,
  input  logic [4:0]       instruction_IF_ID_Rt,
  input  logic             uses_rt_IF_ID,
  input  logic             branch_taken_EXE_MEM,
  input  logic             mem_access_EXE_MEM,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             pipe_write,
  output logic             id_exe_bubble,
  output logic             flush,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic [15:0]        wait_cnt_r;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic               mem_error_r;
  logic               freeze_s;
  logic               hazard_s;

  // Freeze and load-use hazard detection
  always_comb begin
    freeze_s = 1'b1;
    case (state_r)
      RUN:      freeze_s = mem_access_EXE_MEM & ~dmem_ready;
      MEM_WAIT: freeze_s = ~dmem_ready;
      ERROR:    freeze_s = 1'b1;
      default:  freeze_s = 1'b1;
    endcase
    hazard_s = mem_read_ID_EXE && (regfile_waddr_ID_EXE != 5'd0) &&
               ((regfile_waddr_ID_EXE == instruction_IF_ID_Rs) ||
                (uses_rt_IF_ID && (regfile_waddr_ID_EXE == instruction_IF_ID_Rt)));
  end

  // Pipeline enables, priority freeze > branch flush > load-use > normal
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    pipe_write    = 1'b1;
    id_exe_bubble = 1'b0;
    flush         = 1'b0;
    if (freeze_s) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_write  = 1'b0;
    end else if (branch_taken_EXE_MEM) begin
      flush = 1'b1;
    end else if (hazard_s) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_exe_bubble = 1'b1;
    end else begin
      flush = 1'b0;
    end
  end

  // Memory-wait FSM with timeout into a reset-only error state
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r     <= RUN;
      wait_cnt_r  <= 16'd0;
      mem_error_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          wait_cnt_r <= 16'd0;
          if (mem_access_EXE_MEM && !dmem_ready) begin
            state_r <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state_r    <= RUN;
            wait_cnt_r <= 16'd0;
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r     <= ERROR;
            wait_cnt_r  <= wait_cnt_r + 16'd1;
            mem_error_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        ERROR: begin
          mem_error_r <= 1'b1;
        end
        default: begin
          state_r    <= RUN;
          wait_cnt_r <= 16'd0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_r <= '0;
    end else if (!pc_write && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end
  end

  assign mem_error    = mem_error_r;
  assign stall_cycles = stall_cnt_r;

endmodule
